lpc_host_io: RTL and testbench

LPC_HOST_IO -- requirements
Module: lpc_host_io

---
 rtl/lpc_host_io_pkg.sv | 38 +++
 rtl/lpc_host_io.sv | 191 +++++++++++++++++++
 tb/tb_lpc_host_io.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lpc_host_io_pkg.sv
// Shared LPC host I/O definitions: FSM state encoding and the fixed LAD nibble codes.
// Used by the host-side I/O cycle engine.
package lpc_host_io_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYC,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR,
        ST_ABORT,
        ST_RESP
    } lpc_state_e;

    localparam logic [3:0] LAD_START  = 4'b0000;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;
    localparam logic [3:0] LAD_ABORT  = 4'b1111;

    // Address nibbles go out most-significant first.
    function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    addr_nibble = addr[15:12];
            2'd1:    addr_nibble = addr[11:8];
            2'd2:    addr_nibble = addr[7:4];
            default: addr_nibble = addr[3:0];
        endcase
    endfunction

endpackage

// File: rtl/lpc_host_io.sv
// LPC host I/O read/write cycle engine; 14 lclk from accept to rsp_valid with zero wait states.
// One request in flight: req_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module lpc_host_io
    import lpc_host_io_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 32,
    parameter int ABORT_LEN    = 4
) (
    input  logic        lclk,
    input  logic        lreset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        lframe_n,
    output logic [3:0]  lad_out,
    output logic        lad_oe,
    input  logic [3:0]  lad_in
);

    localparam int CNT_MAX = (SYNC_TIMEOUT > ABORT_LEN) ? SYNC_TIMEOUT : ABORT_LEN;
    localparam int CW      = ($clog2(CNT_MAX + 1) < 2) ? 2 : $clog2(CNT_MAX + 1);

    lpc_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_en_q;
    logic        sync_wait;

    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    // req_ready is held off until the first edge after reset release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sync_wait = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        lframe_n  = 1'b1;
        lad_oe    = 1'b0;
        lad_out   = LAD_ABORT;

        case (state_q)
            ST_IDLE: begin
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                lframe_n = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = LAD_START;
                state_d  = ST_CYC;
            end
            ST_CYC: begin
                lad_oe  = 1'b1;
                lad_out = wr_q ? CYC_IO_WR : CYC_IO_RD;
                cnt_d   = '0;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                lad_oe  = 1'b1;
                lad_out = addr_nibble(addr_q, cnt_q[1:0]);
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = wr_q ? ST_WDATA : ST_HTAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WDATA: begin
                lad_oe  = 1'b1;
                lad_out = cnt_q[0] ? wdata_q[7:4] : wdata_q[3:0];
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = ST_HTAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HTAR: begin
                // Drive 1111 for one cycle, then float the bus for the peripheral.
                if (!cnt_q[0]) begin
                    lad_oe = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                case (lad_in)
                    SYNC_READY, SYNC_ERROR: begin
                        err_d   = err_q | (lad_in == SYNC_ERROR);
                        cnt_d   = '0;
                        state_d = wr_q ? ST_PTAR : ST_RDATA;
                    end
                    SYNC_SHORT, SYNC_LONG: sync_wait = 1'b1;
                    default:               sync_wait = 1'b1;
                endcase
                if (sync_wait) begin
                    if (cnt_q == CW'(SYNC_TIMEOUT - 1)) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_RDATA: begin
                if (!cnt_q[0]) begin
                    rdata_d[3:0] = lad_in;
                    cnt_d        = cnt_q + CW'(1);
                end else begin
                    rdata_d[7:4] = lad_in;
                    cnt_d        = '0;
                    state_d      = ST_PTAR;
                end
            end
            ST_PTAR: begin
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ABORT: begin
                lframe_n = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = LAD_ABORT;
                if (cnt_q == CW'(ABORT_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : 8'h00;
    assign rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_lpc_host_io.sv
// Directed bench for lpc_host_io: the bench plays the LAD peripheral and
// compares bus nibbles, latency and responses against hand-computed values.
module tb_lpc_host_io;

    logic        lclk = 1'b0;
    logic        lreset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        lframe_n;
    logic [3:0]  lad_out;
    logic        lad_oe;
    logic [3:0]  lad_in = 4'hF;

    int n_assert = 0;
    int n_fail   = 0;

    int          acc_wait, lat, nseq, nlow, nrdy;
    logic [7:0]  rdat;
    logic        err;
    logic [31:0] seq;

    lpc_host_io #(.SYNC_TIMEOUT(32), .ABORT_LEN(4)) dut (
        .lclk      (lclk),
        .lreset_n  (lreset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .lframe_n  (lframe_n),
        .lad_out   (lad_out),
        .lad_oe    (lad_oe),
        .lad_in    (lad_in)
    );

    always #15 lclk = ~lclk;

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and acts as the peripheral: SYNC window opens at
    // cycle 11 (write) or 9 (read) after the acceptance edge.
    task automatic do_txn(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                          input int nwait, input logic [3:0] wnib, input logic [3:0] code,
                          input logic [7:0] rd, input logic hold,
                          output int o_acc, output int o_lat, output logic [7:0] o_rdat,
                          output logic o_err, output logic [31:0] o_seq, output int o_nseq,
                          output int o_nlow, output int o_nrdy);
        int s;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        o_acc = 0;
        while (!req_ready && o_acc < 20) begin
            tick();
            o_acc++;
        end
        tick();
        if (!hold) req_valid = 1'b0;
        s = wr ? 11 : 9;
        o_lat = -1; o_rdat = 8'h00; o_err = 1'b0; o_seq = '0;
        o_nseq = 0; o_nlow = 0; o_nrdy = 0;
        for (int c = 1; c <= 100; c++) begin
            if (rsp_valid) begin
                o_lat  = c;
                o_rdat = rsp_rdata;
                o_err  = rsp_err;
                break;
            end
            if (lad_oe) begin
                o_seq = {o_seq[27:0], lad_out};
                o_nseq++;
            end
            if (!lframe_n) o_nlow++;
            if (req_ready) o_nrdy++;
            if (c >= s && c < s + nwait)            lad_in = wnib;
            else if (c == s + nwait)                lad_in = code;
            else if (!wr && c == s + nwait + 1)     lad_in = rd[3:0];
            else if (!wr && c == s + nwait + 2)     lad_in = rd[7:4];
            else                                    lad_in = 4'hF;
            tick();
        end
        lad_in = 4'hF;
    endtask

    initial begin
        // Reset state
        #2 lreset_n = 1'b0;
        #1;
        check("rst_lframe_n", 32'(lframe_n), 32'h1);
        check("rst_lad_oe",   32'(lad_oe),   32'h0);
        check("rst_lad_out",  32'(lad_out),  32'hF);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        tick();
        check("rst_req_ready_edge", 32'(req_ready), 32'h0);
        lreset_n = 1'b1;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        check("idle_lad_out", 32'(lad_out), 32'hF);

        // Zero-wait write 0x0080 <- 0x5A
        do_txn(1'b1, 16'h0080, 8'h5A, 0, 4'h6, 4'h0, 8'h00, 1'b0,
               acc_wait, lat, rdat, err, seq, nseq, nlow, nrdy);
        check("wr_acc_wait", 32'(acc_wait), 32'd0);
        check("wr_latency",  32'(lat),      32'd14);
        check("wr_err",      32'(err),      32'h0);
        check("wr_rdata",    32'(rdat),     32'h00);
        check("wr_lad_seq",  seq,           32'h20080A5F);
        check("wr_lad_cnt",  32'(nseq),     32'd9);
        check("wr_lframe_lo", 32'(nlow),    32'd1);

        // Read 0x4701, three long waits, data 0xC3; request held to probe acceptance
        do_txn(1'b0, 16'h4701, 8'h00, 3, 4'h6, 4'h0, 8'hC3, 1'b1,
               acc_wait, lat, rdat, err, seq, nseq, nlow, nrdy);
        check("rd_acc_wait", 32'(acc_wait), 32'd1);
        check("rd_latency",  32'(lat),      32'd17);
        check("rd_rdata",    32'(rdat),     32'hC3);
        check("rd_err",      32'(err),      32'h0);
        check("rd_lad_seq",  seq,           32'h0004701F);
        check("rd_lad_cnt",  32'(nseq),     32'd7);
        check("rd_hold_no_ready", 32'(nrdy), 32'd0);

        // Write 0x03F8 <- 0x3C with SYNC error; valid still high from the held request
        do_txn(1'b1, 16'h03F8, 8'h3C, 0, 4'h6, 4'hA, 8'h00, 1'b0,
               acc_wait, lat, rdat, err, seq, nseq, nlow, nrdy);
        check("wrerr_acc_wait", 32'(acc_wait), 32'd1);
        check("wrerr_latency",  32'(lat),      32'd14);
        check("wrerr_err",      32'(err),      32'h1);
        check("wrerr_rdata",    32'(rdat),     32'h00);
        check("wrerr_lad_seq",  seq,           32'h203F8C3F);

        // Read 0x0060: one short wait then error, data still returned
        do_txn(1'b0, 16'h0060, 8'h00, 1, 4'h5, 4'hA, 8'h96, 1'b0,
               acc_wait, lat, rdat, err, seq, nseq, nlow, nrdy);
        check("rderr_acc_wait", 32'(acc_wait), 32'd1);
        check("rderr_latency",  32'(lat),      32'd15);
        check("rderr_err",      32'(err),      32'h1);
        check("rderr_rdata",    32'(rdat),     32'h96);
        check("rderr_lad_seq",  seq,           32'h0000060F);

        // Read with no SYNC: 32 SYNC cycles, 4-cycle abort
        do_txn(1'b0, 16'h4701, 8'h00, 1000, 4'hF, 4'hF, 8'h00, 1'b0,
               acc_wait, lat, rdat, err, seq, nseq, nlow, nrdy);
        check("to_latency",   32'(lat),  32'd45);
        check("to_err",       32'(err),  32'h1);
        check("to_rdata",     32'(rdat), 32'h00);
        check("to_lframe_lo", 32'(nlow), 32'd5);
        check("to_lad_seq",   seq,       32'h701FFFFF);
        check("to_lad_cnt",   32'(nseq), 32'd11);

        // Reset during ADDR
        tick();
        check("pre_mid_rst_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4701;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_addr_oe",     32'(lad_oe),  32'h1);
        check("mid_addr_nibble", 32'(lad_out), 32'h4);
        #5 lreset_n = 1'b0;
        #1;
        check("mid_rst_lframe_n", 32'(lframe_n),  32'h1);
        check("mid_rst_lad_oe",   32'(lad_oe),    32'h0);
        check("mid_rst_lad_out",  32'(lad_out),   32'hF);
        check("mid_rst_ready",    32'(req_ready), 32'h0);
        tick();
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        lreset_n = 1'b1;
        tick();
        check("mid_rst_ready_after", 32'(req_ready), 32'h1);
        nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) nrdy++;
            tick();
        end
        check("mid_rst_no_rsp", 32'(nrdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
